// File: rtl/edge_event_rr_scheduler.sv
// Any-edge detector on NBITS status lines. Detected edges are latched as pending
// events and handed out one at a time, round-robin, over a val/rdy interface.
module edge_event_rr_scheduler #(
    parameter  int NBITS = 8,
    localparam int IDXW  = $clog2(NBITS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [NBITS-1:0] in_,
    output logic             evt_val,
    input  logic             evt_rdy,
    output logic [IDXW-1:0]  evt_idx,
    output logic             evt_rise,
    output logic [NBITS-1:0] pending,
    output logic [NBITS-1:0] overflow,
    input  logic             clr_ovf
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state, state_nxt;
    logic             run;
    logic [NBITS-1:0] prev, dir, edg, fire_vec, ovf_set;
    logic [IDXW-1:0]  ptr, lock_idx, scan_idx, sel_idx;
    logic             lock, fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // INIT only loads prev, so the first sample after reset never looks like an edge
    always_comb begin
        run = (state == ST_RUN);
    end

    // Lowest offset from ptr wins: iterate from the far end so nearer hits overwrite
    always_comb begin
        int j;
        j        = 0;
        scan_idx = '0;
        for (int k = NBITS - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NBITS;
            if (pending[j]) scan_idx = IDXW'(j);
        end
    end

    assign sel_idx  = lock ? lock_idx : scan_idx;
    assign evt_val  = |pending;
    assign evt_idx  = sel_idx;
    assign evt_rise = dir[sel_idx];
    assign fire     = evt_val & evt_rdy;
    assign fire_vec = fire ? (NBITS'(1) << sel_idx) : '0;
    assign edg      = (run & en) ? (prev ^ in_) : '0;
    assign ovf_set  = edg & pending & ~fire_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            pending  <= '0;
            dir      <= '0;
            overflow <= '0;
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else begin
            prev     <= in_;
            overflow <= (clr_ovf ? '0 : overflow) | ovf_set;
            for (int i = 0; i < NBITS; i++) begin
                if (edg[i]) begin
                    pending[i] <= 1'b1;
                    // a still-queued event keeps its original direction
                    if (!pending[i] || fire_vec[i]) dir[i] <= in_[i];
                end else if (fire_vec[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (fire) begin
                lock <= 1'b0;
                ptr  <= (sel_idx == IDXW'(NBITS - 1)) ? '0 : sel_idx + 1'b1;
            end else if (evt_val && !evt_rdy) begin
                lock     <= 1'b1;
                lock_idx <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_rr_scheduler.sv
// Directed bench for edge_event_rr_scheduler: inputs change and outputs are
// checked on the falling edge, each step advancing exactly one rising edge.
module tb_edge_event_rr_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] in_;
    logic       evt_val;
    logic       evt_rdy;
    logic [2:0] evt_idx;
    logic       evt_rise;
    logic [7:0] pending;
    logic [7:0] overflow;
    logic       clr_ovf;

    int tests = 0;
    int fails = 0;

    edge_event_rr_scheduler #(.NBITS(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .in_      (in_),
        .evt_val  (evt_val),
        .evt_rdy  (evt_rdy),
        .evt_idx  (evt_idx),
        .evt_rise (evt_rise),
        .pending  (pending),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_evt(input string tag, input logic v, input logic [2:0] idx, input logic r);
        chk({tag, ".val"},  32'(evt_val),  32'(v));
        chk({tag, ".idx"},  32'(evt_idx),  32'(idx));
        chk({tag, ".rise"}, 32'(evt_rise), 32'(r));
    endtask

    initial begin
        reset_n = 1'b1; en = 1'b1; in_ = 8'hFF; evt_rdy = 1'b0; clr_ovf = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk_evt("rst", 1'b0, 3'd0, 1'b0);
        chk("rst.pending",  32'(pending),  32'h00);
        chk("rst.overflow", 32'(overflow), 32'h00);
        step();
        reset_n = 1'b1;

        // 1: FF held through INIT produces no event
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t1.val", 32'(evt_val), 32'd0);
        end

        // 2: single rising edge on bit 2
        en = 1'b0; in_ = 8'h00; step();
        en = 1'b1; in_ = 8'h04; evt_rdy = 1'b1; step();
        chk_evt("t2", 1'b1, 3'd2, 1'b1);
        step();
        chk("t2.pending", 32'(pending), 32'h00);

        // 3: bits 7 and 0 together, ptr=3 -> 7 then 0
        en = 1'b0; in_ = 8'h00; step();
        en = 1'b1; in_ = 8'h81; step();
        chk_evt("t3a", 1'b1, 3'd7, 1'b1);
        step();
        chk_evt("t3b", 1'b1, 3'd0, 1'b1);
        step();
        chk("t3.val", 32'(evt_val), 32'd0);
        // ptr should now be 1: bits 0,1 together grant 1 first
        en = 1'b0; in_ = 8'h00; step();
        en = 1'b1; in_ = 8'h03; step();
        chk_evt("t3c", 1'b1, 3'd1, 1'b1);
        step();
        chk_evt("t3d", 1'b1, 3'd0, 1'b1);
        step();
        // fire bit 7 to bring ptr to 0
        en = 1'b0; in_ = 8'h00; step();
        en = 1'b1; in_ = 8'h80; step();
        chk_evt("t3e", 1'b1, 3'd7, 1'b1);
        step();
        chk("t3.pending", 32'(pending), 32'h00);

        // 4: locked grant on bit 5 must hold while bit 1 arrives
        en = 1'b0; in_ = 8'h00; evt_rdy = 1'b0; step();
        en = 1'b1; in_ = 8'h20; step();
        chk_evt("t4a", 1'b1, 3'd5, 1'b1);
        in_ = 8'h22; step();
        chk("t4.pending", 32'(pending), 32'h22);
        chk_evt("t4b", 1'b1, 3'd5, 1'b1);
        step();
        chk_evt("t4c", 1'b1, 3'd5, 1'b1);
        evt_rdy = 1'b1; step();
        chk_evt("t4d", 1'b1, 3'd1, 1'b1);
        step();
        chk("t4.drain", 32'(pending), 32'h00);

        // 5: overflow keeps oldest direction; clr_ovf loses to same-cycle set
        evt_rdy = 1'b0; in_ = 8'h2A; step();
        chk_evt("t5a", 1'b1, 3'd3, 1'b1);
        in_ = 8'h22; step();
        chk("t5.ovf", 32'(overflow), 32'h08);
        chk_evt("t5b", 1'b1, 3'd3, 1'b1);
        clr_ovf = 1'b1; in_ = 8'h2A; step();
        chk("t5.ovf_win", 32'(overflow), 32'h08);
        step();
        chk("t5.ovf_clr", 32'(overflow), 32'h00);
        clr_ovf = 1'b0; evt_rdy = 1'b1; step();
        chk("t5.drain", 32'(pending), 32'h00);
        // edge on bit 3 in the same cycle it fires: re-armed, new direction
        evt_rdy = 1'b0; in_ = 8'h22; step();
        chk_evt("t5c", 1'b1, 3'd3, 1'b0);
        evt_rdy = 1'b1; in_ = 8'h2A; step();
        chk("t5.same_pend", 32'(pending), 32'h08);
        chk("t5.same_ovf",  32'(overflow), 32'h00);
        chk_evt("t5d", 1'b1, 3'd3, 1'b1);
        step();
        chk("t5.drain2", 32'(pending), 32'h00);

        // 6: en=0 blocks new edges but latched events drain
        evt_rdy = 1'b0; in_ = 8'h2B; step();
        chk("t6.pend", 32'(pending), 32'h01);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_ = (c % 2 == 0) ? 8'h55 : 8'hAA; step();
            chk("t6.hold", 32'(pending), 32'h01);
        end
        evt_rdy = 1'b1; in_ = 8'h55; step();
        chk("t6.drain", 32'(pending), 32'h00);
        chk("t6.val",   32'(evt_val), 32'd0);
        in_ = 8'hAA; step();
        chk("t6.en0", 32'(pending), 32'h00);
        en = 1'b1; evt_rdy = 1'b0; in_ = 8'h55; step();
        chk("t6.burst", 32'(pending), 32'hFF);
        in_ = 8'hAA; step();
        chk("t6.burst_ovf", 32'(overflow), 32'hFF);
        #2 reset_n = 1'b0;
        #1;
        chk("t6.async_val", 32'(evt_val),  32'd0);
        chk("t6.async_pnd", 32'(pending),  32'h00);
        chk("t6.async_ovf", 32'(overflow), 32'h00);
        step();
        reset_n = 1'b1;
        step(); step();
        chk("t6.reinit", 32'(evt_val), 32'd0);
        in_ = 8'hA8; step();
        chk_evt("t6.after", 1'b1, 3'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
